seq_mult_acc: RTL and testbench

Parametrised sequential shift-and-add multiplier with optional signed mode and a running accumulator. It generalises the team's small combinational arithmetic blocks. It trades area for latency, processing one multiplier bit per clock, and sits behind a valid/ready handshake so it can be driven from the pin wrapper or an upstream controller. The accumulator supports multiply-accumulate (MAC) sequences, with a sticky overflow flag.

---
 rtl/seq_mult_acc.sv | 161 ++++++++++++++++
 tb/tb_seq_mult_acc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_acc.sv
// seq_mult_acc: shift-and-add multiplier, one multiplier bit per clock,
// with optional signed mode and a sticky-overflow running accumulator.
module seq_mult_acc #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 mode_signed,
   input  logic                 accumulate,
   input  logic                 clear_acc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [ACC_W-1:0]     acc,
   output logic                 overflow,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     partial_q, partial_d;
   logic              neg_q, neg_d;
   logic              sgn_q, sgn_d;
   logic              acc_en_q, acc_en_d;
   logic [PW-1:0]     product_q, product_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;

   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [PW-1:0]     partial_nx;
   logic [PW-1:0]     prod_nx;
   logic [ACC_W-1:0]  ext;
   logic [ACC_W-1:0]  base;
   logic [ACC_W:0]    sum;
   logic              ovf_add;

   // Operand magnitudes, next partial product and accumulator add path
   always_comb begin
      mag_a = (mode_signed && a[WIDTH-1]) ? -a : a;
      mag_b = (mode_signed && b[WIDTH-1]) ? -b : b;
      partial_nx = partial_q + (mplier_q[0] ? mcand_q : '0);
      prod_nx = neg_q ? -partial_nx : partial_nx;
      if (sgn_q) begin
         ext = ACC_W'($signed(prod_nx));
      end else begin
         ext = ACC_W'(prod_nx);
      end
      // A coincident clear zeroes the addend base, so the add sees 0
      base = clear_acc ? '0 : acc_q;
      sum = {1'b0, base} + {1'b0, ext};
      if (sgn_q) begin
         ovf_add = (base[ACC_W-1] == ext[ACC_W-1])
                && (sum[ACC_W-1] != base[ACC_W-1]);
      end else begin
         ovf_add = sum[ACC_W];
      end
   end

   // Next-state and datapath control for IDLE/RUN/DONE
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      partial_d = partial_q;
      neg_d     = neg_q;
      sgn_d     = sgn_q;
      acc_en_d  = acc_en_q;
      product_d = product_q;
      acc_d     = clear_acc ? '0 : acc_q;
      ovf_d     = clear_acc ? 1'b0 : ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d   = PW'(mag_a);
               mplier_d  = mag_b;
               neg_d     = mode_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               sgn_d     = mode_signed;
               acc_en_d  = accumulate;
               partial_d = '0;
               cnt_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            partial_d = partial_nx;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               product_d = prod_nx;
               state_d   = DONE;
               if (acc_en_q) begin
                  acc_d = sum[ACC_W-1:0];
                  ovf_d = (clear_acc ? 1'b0 : ovf_q) | ovf_add;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         partial_q <= '0;
         neg_q     <= 1'b0;
         sgn_q     <= 1'b0;
         acc_en_q  <= 1'b0;
         product_q <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         partial_q <= partial_d;
         neg_q     <= neg_d;
         sgn_q     <= sgn_d;
         acc_en_q  <= acc_en_d;
         product_q <= product_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign product   = product_q;
   assign acc       = acc_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_mult_acc.sv
// tb_seq_mult_acc: directed and random checks of seq_mult_acc against an
// arithmetic reference model, with accumulator widths 24 and 17.
module tb_seq_mult_acc;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, mode_signed, accumulate, clear_acc, out_ready;
   logic [W-1:0] a, b;

   logic in_ready1, out_valid1, ovf1, busy1;
   logic in_ready2, out_valid2, ovf2, busy2;
   logic [2*W-1:0] product1, product2;
   logic [23:0] acc1;
   logic [16:0] acc2;

   int tests = 0;
   int fails = 0;

   longint macc [2];
   bit     movf [2];
   int     aw   [2] = '{24, 17};
   logic [2*W-1:0] ep;

   logic [W-1:0] cur_a, cur_b;
   bit cur_s, cur_acc;

   always #5 clk = ~clk;

   seq_mult_acc #(.WIDTH(W), .ACC_W(24)) d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .mode_signed(mode_signed), .accumulate(accumulate),
      .clear_acc(clear_acc), .out_valid(out_valid1), .out_ready(out_ready),
      .product(product1), .acc(acc1), .overflow(ovf1), .busy(busy1)
   );

   seq_mult_acc #(.WIDTH(W), .ACC_W(17)) d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .mode_signed(mode_signed), .accumulate(accumulate),
      .clear_acc(clear_acc), .out_valid(out_valid2), .out_ready(out_ready),
      .product(product2), .acc(acc2), .overflow(ovf2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: true integer product, accumulator kept as an integer mod 2^N
   function automatic void model_op(input logic [W-1:0] xa, xb,
                                    input bit s, accum, clr);
      longint pv;
      if (s) pv = longint'($signed(xa)) * longint'($signed(xb));
      else   pv = longint'(xa) * longint'(xb);
      ep = pv[2*W-1:0];
      for (int k = 0; k < 2; k++) begin
         longint md, e, ns, sa, ss;
         bit o;
         md = longint'(1) << aw[k];
         if (clr) begin
            macc[k] = 0;
            movf[k] = 0;
         end
         if (accum) begin
            e  = pv & (md - 1);
            ns = macc[k] + e;
            if (s) begin
               sa = (macc[k] >= md / 2) ? macc[k] - md : macc[k];
               ss = sa + pv;
               o  = (ss < -(md / 2)) || (ss >= md / 2);
            end else begin
               o = (ns >= md);
            end
            macc[k] = ns & (md - 1);
            movf[k] = movf[k] | o;
         end
      end
   endfunction

   task automatic chk_acc(input string tag);
      chk({tag, "_acc24"}, 64'(acc1), 64'(macc[0]));
      chk({tag, "_acc17"}, 64'(acc2), 64'(macc[1]));
      chk({tag, "_ovf24"}, 64'(ovf1), 64'(movf[0]));
      chk({tag, "_ovf17"}, 64'(ovf2), 64'(movf[1]));
   endtask

   task automatic start_op(input logic [W-1:0] xa, xb, input bit s, accum);
      chk("idle_ready", 64'(in_ready1 & in_ready2), 64'(1));
      cur_a = xa; cur_b = xb; cur_s = s; cur_acc = accum;
      a = xa; b = xb; mode_signed = s; accumulate = accum;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      mode_signed = ~s; accumulate = ~accum;
      chk("accept_busy", 64'(busy1), 64'(1));
   endtask

   task automatic run_op(input bit clr);
      for (int i = 1; i <= W; i++) begin
         if (i == W) clear_acc = clr;
         @(posedge clk); #1;
         clear_acc = 1'b0;
         chk("run_out_valid", 64'(out_valid1), 64'(i == W));
         if (i == W || i == 1) begin
            chk("run_in_ready", 64'(in_ready1), 64'(0));
            chk("run_busy", 64'(busy1), 64'(1));
         end
      end
      model_op(cur_a, cur_b, cur_s, cur_acc, clr);
      chk("product", 64'(product1), 64'(ep));
      chk("product17", 64'(product2), 64'(ep));
      chk_acc("done");
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("drain_out_valid", 64'(out_valid1), 64'(0));
      chk("drain_in_ready", 64'(in_ready1), 64'(1));
      chk("drain_busy", 64'(busy1), 64'(0));
   endtask

   task automatic do_op(input logic [W-1:0] xa, xb, input bit s, accum, clr);
      start_op(xa, xb, s, accum);
      run_op(clr);
      drain();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready1), 64'(1));
      chk({tag, "_out_valid"}, 64'(out_valid1), 64'(0));
      chk({tag, "_busy"}, 64'(busy1), 64'(0));
      chk({tag, "_product"}, 64'(product1), 64'(0));
      chk({tag, "_acc"}, 64'(acc1), 64'(0));
      chk({tag, "_ovf"}, 64'(ovf1), 64'(0));
      chk({tag, "_ovf17"}, 64'(ovf2), 64'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; mode_signed = 1'b0; accumulate = 1'b0;
      clear_acc = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      macc[0] = 0; macc[1] = 0; movf[0] = 0; movf[1] = 0;
      #2;
      chk_reset("rst");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Unsigned 200*150 with latency and handshake checks
      do_op(8'd200, 8'd150, 1'b0, 1'b0, 1'b0);
      chk("u200x150", 64'(product1), 64'h7530);
      start_op(8'd200, 8'd150, 1'b0, 1'b0);
      run_op(1'b0);
      drain();

      // Signed cases
      do_op(8'hF9, 8'd9, 1'b1, 1'b0, 1'b0);
      chk("s_m7x9", 64'(product1), 64'hFFC1);
      start_op(8'h80, 8'h80, 1'b1, 1'b0);
      run_op(1'b0);
      chk("s_min_min", 64'(product1), 64'h4000);
      drain();
      do_op(8'h00, 8'h80, 1'b1, 1'b0, 1'b0);
      chk("s_zero", 64'(product1), 64'h0);

      // Backpressure with a pending request
      start_op(8'd13, 8'd11, 1'b0, 1'b0);
      run_op(1'b0);
      a = 8'd7; b = 8'd6; mode_signed = 1'b0; accumulate = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", 64'(out_valid1), 64'(1));
         chk("bp_product", 64'(product1), 64'd143);
         chk("bp_in_ready", 64'(in_ready1), 64'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_ready", 64'(in_ready1), 64'(1));
      chk("bp_release_valid", 64'(out_valid1), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept_busy", 64'(busy1), 64'(1));
      cur_a = 8'd7; cur_b = 8'd6; cur_s = 1'b0; cur_acc = 1'b0;
      run_op(1'b0);
      chk("bp_pending", 64'(product1), 64'd42);
      drain();

      // Accumulate 255*255 three times
      clear_acc = 1'b1;
      @(posedge clk); #1;
      clear_acc = 1'b0;
      model_op(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      chk_acc("clr_idle");
      for (int i = 0; i < 3; i++) do_op(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
      chk("mac24", 64'(acc1), 64'h02FA03);
      chk("mac24_ovf", 64'(ovf1), 64'(0));
      chk("mac17", 64'(acc2), 64'h0FA03);
      chk("mac17_ovf", 64'(ovf2), 64'(1));
      do_op(8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
      chk("mac17_sticky", 64'(ovf2), 64'(1));
      chk("mac17_hold", 64'(acc2), 64'h0FA03);

      // Clear coincident with an accumulate write
      do_op(8'd12, 8'd10, 1'b0, 1'b1, 1'b1);
      chk("clr_add24", 64'(acc1), 64'd120);
      chk("clr_add17", 64'(acc2), 64'd120);
      chk("clr_add_ovf", 64'(ovf2), 64'(0));

      // Random operations against the model
      for (int i = 0; i < 30; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end

      // Reset mid-RUN
      do_op(8'd5, 8'd7, 1'b0, 1'b1, 1'b0);
      start_op(8'd9, 8'd9, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset("midrun_rst");
      macc[0] = 0; macc[1] = 0; movf[0] = 0; movf[1] = 0;
      #3 rst_n = 1'b1;
      for (int i = 0; i < W + 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_valid", 64'(out_valid1), 64'(0));
      end
      do_op(8'd3, 8'd5, 1'b0, 1'b0, 1'b0);
      chk("post_rst_3x5", 64'(product1), 64'd15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
